// File: rtl/gcd_lcm_stage.sv
// LCM stage behind the GCD core: lcm = (a*b)/gcd via one multiply edge and a restoring divider.
// Define LCM_STAGE_INBUF_EN to add a one-entry operand buffer that accepts a new set while busy.
`timescale 1ns/1ps

module gcd_lcm_stage #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_gcd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] lcm,
    output logic               zero_err,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  g_r;
    logic [WIDTH-1:0]  rem;
    logic [PW-1:0]     prod;
    logic [CW-1:0]     cnt;

    logic [WIDTH:0]    rem_shift;
    logic [WIDTH-1:0]  rem_sub;
    logic [WIDTH-1:0]  rem_next;
    logic              q_bit;
    logic              accept;
    logic              handshake;

`ifdef LCM_STAGE_INBUF_EN
    logic              buf_full;
    logic [WIDTH-1:0]  buf_a;
    logic [WIDTH-1:0]  buf_b;
    logic [WIDTH-1:0]  buf_g;

    assign in_ready = (state == IDLE) || !buf_full;
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept    = in_valid && in_ready;
    assign handshake = (state == DONE) && out_valid && out_ready;

    // The remainder is always below g, so the subtraction fits in WIDTH bits
    // whenever it is taken; the shifted-in top bit only matters for the compare.
    always_comb begin
        rem_shift = {rem, prod[PW-1]};
        q_bit     = (rem_shift >= {1'b0, g_r});
        rem_sub   = rem_shift[WIDTH-1:0] - g_r;
        rem_next  = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            g_r       <= '0;
            rem       <= '0;
            prod      <= '0;
            cnt       <= '0;
            lcm       <= '0;
            zero_err  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef LCM_STAGE_INBUF_EN
            buf_full  <= 1'b0;
            buf_a     <= '0;
            buf_b     <= '0;
            buf_g     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        g_r   <= in_gcd;
                        state <= MUL;
                        busy  <= 1'b1;
                    end
                end

                MUL: begin
                    prod <= PW'(a_r) * PW'(b_r);
                    rem  <= '0;
                    cnt  <= CW'(PW - 1);
                    if (g_r == '0) begin
                        lcm      <= '0;
                        zero_err <= 1'b1;
                        state    <= DONE;
                    end else begin
                        zero_err <= 1'b0;
                        state    <= DIV;
                    end
                end

                // Dividend bits leave prod at the top while quotient bits enter at the bottom.
                DIV: begin
                    rem  <= rem_next;
                    prod <= {prod[PW-2:0], q_bit};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        lcm   <= {prod[PW-2:0], q_bit};
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef LCM_STAGE_INBUF_EN
                        if (buf_full) begin
                            a_r      <= buf_a;
                            b_r      <= buf_b;
                            g_r      <= buf_g;
                            buf_full <= 1'b0;
                            state    <= MUL;
                        end else if (accept) begin
                            a_r   <= in_a;
                            b_r   <= in_b;
                            g_r   <= in_gcd;
                            state <= MUL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end

                default: state <= IDLE;
            endcase

`ifdef LCM_STAGE_INBUF_EN
            // A set arriving while busy parks in the buffer unless the handshake frees the datapath now.
            if (accept && (state != IDLE) && !(handshake && !buf_full)) begin
                buf_a    <= in_a;
                buf_b    <= in_b;
                buf_g    <= in_gcd;
                buf_full <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gcd_lcm_stage.sv
// Directed self-checking bench for gcd_lcm_stage with hand-computed LCM results and latencies.
// Buffer-specific checks build only when LCM_STAGE_INBUF_EN is defined.
`timescale 1ns/1ps

module tb_gcd_lcm_stage;

    localparam int WIDTH = 8;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   in_gcd;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] lcm;
    logic               zero_err;
    logic               busy;

    int checks;
    int errors;

`ifdef LCM_STAGE_INBUF_EN
    localparam logic READY_WHILE_BUSY = 1'b1;
`else
    localparam logic READY_WHILE_BUSY = 1'b0;
`endif

    gcd_lcm_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_gcd    (in_gcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lcm       (lcm),
        .zero_err  (zero_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Offers one operand set at a negedge; returns just after the accept edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] g);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_gcd   = g;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 100);
        if (!out_valid) checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic runVector(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] g, input int exp_lcm, input logic exp_zero,
                             input int exp_lat);
        int lat;
        applyStimulus(a, b, g);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_lcm"}, 32'(lcm), 32'(exp_lcm));
        checkOutput({tag, "_zero_err"}, 32'(zero_err), 32'(exp_zero));
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_gcd    = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_lcm", 32'(lcm), 32'd0);
        checkOutput("rst_zero_err", 32'(zero_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] basic vectors");
        runVector("v80_10", 8'd80, 8'd10, 8'd10, 80, 1'b0, 18);
        runVector("v255_254", 8'd255, 8'd254, 8'd1, 64770, 1'b0, 18);
        runVector("zero_gcd", 8'd0, 8'd0, 8'd0, 0, 1'b1, 2);

        // A set offered mid-computation is dropped without the buffer.
        applyStimulus(8'd12, 8'd18, 8'd6);
        repeat (3) @(negedge clk);
        checkOutput("busy_in_ready", 32'(in_ready), 32'(READY_WHILE_BUSY));
`ifndef LCM_STAGE_INBUF_EN
        in_a     = 8'd5;
        in_b     = 8'd5;
        in_gcd   = 8'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
`endif
        waitResult(lat);
        checkOutput("v12_18_lcm", 32'(lcm), 32'd36);
        @(posedge clk);
        #1;
        checkOutput("v12_18_idle", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("dropped_set_ignored", 32'(busy), 32'd0);

        $display("[TB] output stall");
        out_ready = 1'b0;
        applyStimulus(8'd80, 8'd40, 8'd40);
        waitResult(lat);
        checkOutput("stall_latency", 32'(lat), 32'd18);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_lcm", 32'(lcm), 32'd80);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'(READY_WHILE_BUSY));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_release_valid", 32'(out_valid), 32'd0);
        checkOutput("stall_release_idle", 32'(busy), 32'd0);

        $display("[TB] reset during divide");
        applyStimulus(8'd80, 8'd10, 8'd10);
        repeat (9) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_lcm", 32'(lcm), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        runVector("v9_6", 8'd9, 8'd6, 8'd3, 18, 1'b0, 18);

`ifdef LCM_STAGE_INBUF_EN
        $display("[TB] input buffer");
        applyStimulus(8'd80, 8'd10, 8'd10);
        repeat (2) @(negedge clk);
        checkOutput("buf_in_ready", 32'(in_ready), 32'd1);
        in_a     = 8'd4;
        in_b     = 8'd6;
        in_gcd   = 8'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("buf_full_ready", 32'(in_ready), 32'd0);
        waitResult(lat);
        checkOutput("buf_first_lcm", 32'(lcm), 32'd80);
        @(posedge clk);
        #1;
        checkOutput("buf_handshake_valid", 32'(out_valid), 32'd0);
        checkOutput("buf_handshake_busy", 32'(busy), 32'd1);
        waitResult(lat);
        checkOutput("buf_second_latency", 32'(lat), 32'd18);
        checkOutput("buf_second_lcm", 32'(lcm), 32'd12);
        @(posedge clk);
        #1;
        checkOutput("buf_final_idle", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_lcm_stage.md
Name: gcd_lcm_stage

Overview:
Downstream consumer of the GCD core. Accepts one operand pair A, B plus their GCD in the cycle the core pulses finish. Computes LCM = (A*B)/GCD with a registered multiply and a shift-subtract restoring divider, then presents the result on a valid/ready output. Sits between the GCD core and the result sink or host readback logic.

Parameters:
WIDTH, 8, operand and GCD width; product, quotient and lcm are 2*WIDTH bits wide.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
in_valid  input  1  operand-set valid; wired to GCD core finish
in_ready  output  1  stage can accept an operand set
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_gcd  input  WIDTH  GCD(A,B) from the core
out_valid  output  1  lcm/zero_err valid
out_ready  input  1  sink accepts the result
lcm  output  2*WIDTH  least common multiple
zero_err  output  1  in_gcd was 0; lcm forced to 0
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (reset=0) -> IDLE; out_valid=0, lcm=0, zero_err=0, busy=0, divider regs=0.
- in_ready = (state==IDLE) when the feature is off.
- Accept edge is any edge with in_valid && in_ready: latch a, b, g; state <= MUL.
- MUL, one edge: prod <= a*b (full 2*WIDTH, unsigned, no truncation); rem <= 0; cnt <= 2*WIDTH-1.
  - If g==0: lcm <= 0, zero_err <= 1, state <= DONE, DIV skipped.
  - Otherwise zero_err <= 0, state <= DIV.
- DIV, one quotient bit per edge, MSB first:
  - rem' = {rem, prod[MSB]}; prod shifts left.
  - If rem' >= g: rem <= rem' - g and quotient bit = 1.
  - Otherwise rem <= rem' and quotient bit = 0.
  - Quotient bits fill prod from the LSB.
  - After 2*WIDTH DIV edges: lcm <= quotient, state <= DONE.
- Latency: out_valid rises 2*WIDTH+2 edges after the accept edge (18 for WIDTH=8). On the zero_err path it rises 2 edges after.
- DONE: out_valid=1.
  - lcm and zero_err hold stable while out_ready=0.
  - Edge with out_ready=1: out_valid <= 0 and state <= IDLE, or MUL if the buffer is occupied (feature on).
- If in_gcd does not divide a*b, the result is floor(a*b/g); no error flag is raised.
- in_valid while not ready (feature off) is dropped; the upstream core holds finish until reset.
- Reset asserted mid-MUL/DIV/DONE: abort; outputs return to reset values asynchronously; the partial result is discarded.
- lcm, out_valid, zero_err and busy are all registered; no combinational path from in_* to out_*.

Optional Feature:
Macro LCM_STAGE_INBUF_EN.
- Defined: adds a one-entry input holding register. in_ready = (state==IDLE) || !buf_full.
  - An operand set accepted while busy is stored in the buffer.
  - On DONE handshake with buf_full: buffer moves to the working regs, buf_full <= 0, state <= MUL.
  - Simultaneous buffer load and DONE handshake: the new set goes directly to the working regs; the buffer stays empty.
  - Reset clears buf_full.
- Undefined: no buffer; behaviour exactly as above.

Test Plan:
- reset low 2 cycles, release; A=80,B=10,G=10, in_valid 1 cycle -> out_valid on 18th edge after accept, lcm=80, zero_err=0.
- A=12,B=18,G=6 -> lcm=36; A=255,B=254,G=1 -> lcm=64770, with no truncation.
- A=0,B=0,G=0 -> out_valid 2 edges after accept, lcm=0, zero_err=1.
- A=80,B=40,G=40 with out_ready low 5 cycles after out_valid -> lcm=80 held stable throughout; in_ready stays 0; IDLE one edge after out_ready=1.
- Pulse reset low during DIV (10 edges after accept) -> immediately out_valid=0, busy=0, lcm=0; next set A=9,B=6,G=3 -> lcm=18.
- LCM_STAGE_INBUF_EN: second set (A=4,B=6,G=2) offered 3 cycles after the first (80,10,10) -> both accepted; results 80 then 12, in order; the second out_valid rises 18 edges after the first handshake.
